// File: rtl/control_alarma_pkg.sv
// Shared types and constants for the alarm decision engine.
`default_nettype none

package control_alarma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RING   = 2'b01,
    SNOOZE = 2'b10,
    ACK    = 2'b11
  } estado_t;

  localparam logic [7:0]  SEG_CERO   = 8'h00;
  localparam int unsigned CLK_HZ_DEF = 100_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_alarma_tick_1s.sv
// One-second tick prescaler; clr restarts the period so intervals are cycle-exact.
`default_nettype none

module tick_1s #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   TERM = PW'(CLK_HZ - 1);

  logic [PW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr || cnt_q == TERM) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PW'(1);
    end
  end

  assign tick = (cnt_q == TERM);

endmodule

`default_nettype wire

// File: rtl/control_alarma.sv
// Alarm decision engine: BCD time match, stop/snooze handling and ring timeout.
// Optional snooze limit enabled by defining CONTROL_ALARMA_LIMITE_POSPONER_EN.
`default_nettype none

module control_alarma
  import control_alarma_pkg::*;
#(
  parameter int unsigned CLK_HZ    = CLK_HZ_DEF,
  parameter int unsigned TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_S  = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hora_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] seg_bcd,
  input  logic [7:0] alarma_hora,
  input  logic [7:0] alarma_min,
  input  logic       alarma_habilitada,
  input  logic       apagar,
  input  logic       posponer,
  output logic       alarma_on,
  output logic [1:0] estado
);

  localparam int unsigned        SEC_MAX   = max_u(TIMEOUT_S, SNOOZE_S);
  localparam int unsigned        SEC_W     = $clog2(SEC_MAX + 1);
  localparam logic [SEC_W-1:0]   SEC_SAT   = SEC_W'(SEC_MAX);
  localparam logic [SEC_W-1:0]   SEC_T_FIN = SEC_W'(TIMEOUT_S - 1);
  localparam logic [SEC_W-1:0]   SEC_S_FIN = SEC_W'(SNOOZE_S - 1);

  estado_t          state_q, state_d;
  logic             alarma_on_q;
  logic [SEC_W-1:0] sec_q;
  logic             tick;
  logic             clr;
  logic             match;
  logic             snz_lleno;

  assign match = alarma_habilitada && (hora_bcd == alarma_hora) &&
                 (min_bcd == alarma_min) && (seg_bcd == SEG_CERO);

`ifdef CONTROL_ALARMA_LIMITE_POSPONER_EN
  logic [1:0] snz_q;

  // Counts snoozes accepted since the alarm last left IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snz_q <= 2'd0;
    end else if (state_q == IDLE) begin
      snz_q <= 2'd0;
    end else if (state_q == RING && state_d == SNOOZE) begin
      snz_q <= snz_q + 2'd1;
    end
  end

  assign snz_lleno = (snz_q == 2'd3);
`else
  assign snz_lleno = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (!alarma_habilitada) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (match) state_d = RING;
        end
        RING: begin
          if (apagar)                               state_d = ACK;
          else if (posponer)                        state_d = snz_lleno ? ACK : SNOOZE;
          else if (tick && sec_q == SEC_T_FIN)      state_d = ACK;
        end
        SNOOZE: begin
          if (apagar)                               state_d = ACK;
          else if (tick && sec_q == SEC_S_FIN)      state_d = RING;
        end
        ACK: begin
          // Hold off until the minute changes so the same match cannot re-trigger.
          if (min_bcd != alarma_min) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign clr = (state_d != state_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      alarma_on_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alarma_on_q <= (state_d == RING);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_q <= '0;
    end else if (clr) begin
      sec_q <= '0;
    end else if (tick && sec_q != SEC_SAT) begin
      sec_q <= sec_q + SEC_W'(1);
    end
  end

  tick_1s #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  assign alarma_on = alarma_on_q;
  assign estado    = state_q;

endmodule

`default_nettype wire

// File: doc/control_alarma.md
Name: control_alarma

Overview:
- Alarm decision engine; drives `alarma_on` into the existing sound block, which generates the amplifier PWM and gating.
- Compares the running RTC time (BCD from the RTC read path) against the user-programmed alarm time.
- Raises `alarma_on`, handles stop and snooze button pulses, and auto-silences after a timeout.
- Sits between the RTC register mirror / user-config logic and the sound block.

Parameters:
- CLK_HZ, 100000000, system clock frequency; the 1 s tick period is CLK_HZ cycles.
- TIMEOUT_S, 60, seconds of ringing before automatic silence.
- SNOOZE_S, 300, seconds of silence after a snooze before ringing resumes.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; 0 resets the block.
- hora_bcd  in  8  current hour, BCD 00-23.
- min_bcd  in  8  current minute, BCD 00-59.
- seg_bcd  in  8  current second, BCD 00-59.
- alarma_hora  in  8  programmed alarm hour, BCD.
- alarma_min  in  8  programmed alarm minute, BCD.
- alarma_habilitada  in  1  level; alarm armed.
- apagar  in  1  one-clk pulse, stop button (already debounced).
- posponer  in  1  one-clk pulse, snooze button (already debounced).
- alarma_on  out  1  registered; high while ringing, connects to the sound block.
- estado  out  2  current FSM state, for the display.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, alarma_on=0, estado=2'b00, tick prescaler=0, second counter=0.
- match = alarma_habilitada && hora_bcd==alarma_hora && min_bcd==alarma_min && seg_bcd==8'h00. Compare on raw BCD bytes; no binary conversion.
- Tick generator: prescaler counts 0..CLK_HZ-1; tick is a one-clk pulse at the terminal count. Prescaler and second counter clear on every state transition, so intervals are exact to the cycle.
- FSM states and encoding:
  - IDLE = 00. Transition to RING when match is high.
  - RING = 01, alarma_on=1. Transitions:
    - apagar -> ACK.
    - posponer -> SNOOZE.
    - second counter reaches TIMEOUT_S on a tick -> ACK.
  - SNOOZE = 10. Transitions:
    - apagar -> ACK.
    - second counter reaches SNOOZE_S -> RING.
    - posponer is ignored.
  - ACK = 11. Transition to IDLE when min_bcd != alarma_min. This prevents re-trigger within the same minute.
- Priority: ~alarma_habilitada (any state -> IDLE) > apagar > posponer > timeout/expiry. apagar and posponer in the same cycle: apagar wins.
- alarma_on is a registered decode of the next state: match sampled at edge N gives alarma_on=1 after edge N+1 (1-cycle latency). Stop has the same 1-cycle latency.
- Second counter width is $clog2(max(TIMEOUT_S,SNOOZE_S)+1). It saturates and never wraps.
- match while in RING/SNOOZE/ACK is ignored.
- Midnight wrap (23:59:59 -> 00:00:00) needs no special handling; an alarma 00:00 matches normally.
- Time inputs are assumed stable per clk (synchronous mirror).

Optional Feature:
- Macro: CONTROL_ALARMA_LIMITE_POSPONER_EN.
- When defined: a 2-bit snooze counter clears on entry to IDLE and increments on each accepted posponer. A posponer in RING when the counter already equals 3 is treated as apagar (-> ACK).
- When undefined: snoozes are unlimited, and no counter is synthesized.

Decomposition:
- Package control_alarma_pkg holds:
  - state typedef/localparams IDLE/RING/SNOOZE/ACK with encodings 00/01/10/11;
  - BCD constant SEG_CERO=8'h00;
  - default CLK_HZ.
- One sub-module: tick_1s (parameter CLK_HZ; ports clk, reset, clr, tick).

Test Plan (CLK_HZ=10, TIMEOUT_S=5, SNOOZE_S=3 for simulation):
- Trigger: alarma 07:30 armed, drive time 07:29:59 -> 07:30:00. Expected: alarma_on=1 one clk after the change; estado=01.
- Timeout: leave ringing untouched. Expected: alarma_on falls exactly 50 clks after entry, estado=11; set min 31 -> estado=00.
- Snooze: pulse posponer while ringing. Expected: alarma_on=0 for exactly 30 clks, then 1 again; pulse apagar -> alarma_on=0, estado=11.
- Simultaneous: apagar and posponer in the same clk during RING. Expected: estado=11, no snooze.
- Disarm/reset mid-ring: drop alarma_habilitada -> estado=00 next clk. Assert reset=0 asynchronously mid-cycle -> alarma_on=0 immediately.
- With CONTROL_ALARMA_LIMITE_POSPONER_EN: fourth posponer. Expected: estado=11 instead of 10.
